pc_fetch_unit: RTL

//  - Holds the program counter and produces incrPC (PC+4).
//  - Consumes the EX-stage branch target (addPCResult) and the ID-stage jump target.
//  - On a redirect, runs a flush FSM that squashes wrong-path fetches for a fixed number of cycles.
//  - Sits at the IF stage: incrPC feeds IF/ID and, later, the PC jump adder in EX;
//    the adder's result loops back here.

---
 rtl/pc_fetch_unit.sv | 93 +++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// IF-stage program counter with branch/jump redirect, wrong-path flush FSM and redirect counter.
// Optional macro PC_ALIGN_CHECK_EN: force redirect targets word-aligned and pulse misalignTrap.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] addPCResult,
    input  logic        jump,
    input  logic [31:0] jumpTarget,
    output logic [31:0] pc,
    output logic [31:0] incrPC,
    output logic        fetchValid,
    output logic        flushActive,
    output logic [7:0]  redirectCount,
    output logic        misalignTrap
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam bit         FLUSH_EN   = (FLUSH_CYCLES != 0);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [3:0]  r_flush_cnt;
    logic [7:0]  r_redirect_cnt;
    logic        r_rst_q;
    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_target_pc;

    // The cycle right after reset release only clears r_rst_q, so the first valid fetch is at RESET_PC.
    assign w_redirect = (branchTaken | jump) & ~r_rst_q;
    assign w_target   = branchTaken ? addPCResult : jumpTarget;

`ifdef PC_ALIGN_CHECK_EN
    logic r_trap;

    assign w_target_pc  = {w_target[31:2], 2'b00};
    assign misalignTrap = r_trap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trap <= 1'b0;
        end else begin
            r_trap <= w_redirect & (w_target[1:0] != 2'b00);
        end
    end
`else
    assign w_target_pc  = w_target;
    assign misalignTrap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc           <= RESET_PC;
            r_state        <= RUN;
            r_flush_cnt    <= '0;
            r_redirect_cnt <= '0;
            r_rst_q        <= 1'b1;
        end else if (r_rst_q) begin
            r_rst_q <= 1'b0;
        end else if (w_redirect) begin
            r_pc <= w_target_pc;
            if (r_redirect_cnt != 8'hFF) begin
                r_redirect_cnt <= r_redirect_cnt + 8'd1;
            end
            if (FLUSH_EN) begin
                r_state     <= FLUSH;
                r_flush_cnt <= FLUSH_LOAD;
            end
        end else if (!stall) begin
            r_pc <= incrPC;
            if (r_state == FLUSH) begin
                r_flush_cnt <= r_flush_cnt - 4'd1;
                if (r_flush_cnt == 4'd1) begin
                    r_state <= RUN;
                end
            end
        end
    end

    assign pc            = r_pc;
    assign incrPC        = r_pc + 32'd4;
    assign flushActive   = (r_state == FLUSH);
    assign fetchValid    = ~r_rst_q & ~stall & ~flushActive;
    assign redirectCount = r_redirect_cnt;

endmodule
